// File: rtl/ram_mailbox_pkg.sv
// Shared constants for the sample-RAM mailbox averager: word map, command
// bits, datapath sizes and the FSM state encoding.
package ram_mailbox_pkg;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_SAMPLE = 2'd1;
    localparam logic [1:0] ADDR_RESULT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int GO_BIT   = 0;
    localparam int CLR_BIT  = 1;
    localparam int SAMPLE_W = 16;
    localparam int TAPS     = 4;
    localparam int SUM_W    = SAMPLE_W + $clog2(TAPS);

    typedef enum logic [3:0] {
        IDLE,
        RD_CMD,
        WAIT_CMD,
        RD_SMP,
        WAIT_SMP,
        CALC,
        WR_OUT,
        WR_STAT,
        WR_CLR
    } state_t;

endpackage

// File: rtl/avg4_core.sv
// 4-tap moving-average datapath: sample history with optional clear, an
// 18-bit signed sum and an arithmetic divide-by-4 extended to 32 bits.
module avg4_core
    import ram_mailbox_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       shift_en,
    input  logic                       clear,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [31:0]         avg
);

    logic signed [SAMPLE_W-1:0] hist [TAPS];
    logic signed [SUM_W-1:0]    sum;

    // NOTE: the history is a handful of flops, not a RAM, so it is reset like
    // any other state; the average after reset must start from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else if (shift_en) begin
            hist[0] <= sample;
            for (int i = 1; i < TAPS; i++) hist[i] <= clear ? '0 : hist[i-1];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) sum = sum + SUM_W'(hist[i]);
        avg = 32'(sum >>> $clog2(TAPS));
    end

endmodule

// File: rtl/ram_mailbox_avg.sv
// Avalon-MM master on RAM port s2: polls the command word, averages one new
// sample into a 4-tap history, writes RESULT, STATUS, then clears GO.
module ram_mailbox_avg
    import ram_mailbox_pkg::*;
#(
    parameter int POLL_INTERVAL = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  address2,
    output logic        chipselect2,
    output logic        write2,
    output logic [31:0] writedata2,
    output logic [3:0]  byteenable2,
    input  logic [31:0] readdata2,
    output logic        busy,
    output logic        done_pulse
);

    localparam int PW = $clog2(POLL_INTERVAL + 1);

    state_t                state, state_nxt;
    logic [PW-1:0]         poll_cnt;
    logic                  poll_done;
    logic                  clr_q;
    logic [SAMPLE_W-1:0]   sample_q;
    logic [15:0]           count_q;
    logic [15:0]           count_inc;
    logic signed [31:0]    avg;
    logic                  unused_rd;

    assign poll_done = (poll_cnt == PW'(POLL_INTERVAL - 1));
    assign count_inc = count_q + 16'd1;
    assign unused_rd = ^readdata2[31:SAMPLE_W];

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            poll_cnt <= '0;
            clr_q    <= 1'b0;
            sample_q <= '0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= (state == IDLE && !poll_done) ? poll_cnt + 1'b1 : '0;
            if (state == WAIT_CMD) clr_q    <= readdata2[CLR_BIT];
            if (state == WAIT_SMP) sample_q <= readdata2[SAMPLE_W-1:0];
            if (state == WR_STAT)  count_q  <= count_inc;
        end
    end

    avg4_core u_core (
        .clk      (clk),
        .reset    (reset),
        .shift_en (state == CALC),
        .clear    (clr_q),
        .sample   (sample_q),
        .avg      (avg)
    );

    always_comb begin
        state_nxt   = state;
        address2    = ADDR_CMD;
        chipselect2 = 1'b0;
        write2      = 1'b0;
        writedata2  = '0;
        busy        = 1'b0;
        done_pulse  = 1'b0;
        case (state)
            IDLE:     if (poll_done) state_nxt = RD_CMD;
            RD_CMD: begin
                chipselect2 = 1'b1;
                address2    = ADDR_CMD;
                state_nxt   = WAIT_CMD;
            end
            WAIT_CMD: state_nxt = readdata2[GO_BIT] ? RD_SMP : IDLE;
            RD_SMP: begin
                busy        = 1'b1;
                chipselect2 = 1'b1;
                address2    = ADDR_SAMPLE;
                state_nxt   = WAIT_SMP;
            end
            WAIT_SMP: begin
                busy      = 1'b1;
                state_nxt = CALC;
            end
            CALC: begin
                busy      = 1'b1;
                state_nxt = WR_OUT;
            end
            WR_OUT: begin
                busy        = 1'b1;
                chipselect2 = 1'b1;
                write2      = 1'b1;
                address2    = ADDR_RESULT;
                writedata2  = avg;
                state_nxt   = WR_STAT;
            end
            WR_STAT: begin
                busy        = 1'b1;
                chipselect2 = 1'b1;
                write2      = 1'b1;
                address2    = ADDR_STATUS;
                writedata2  = {count_inc, 15'b0, 1'b1};
                state_nxt   = WR_CLR;
            end
            WR_CLR: begin
                busy        = 1'b1;
                chipselect2 = 1'b1;
                write2      = 1'b1;
                address2    = ADDR_CMD;
                done_pulse  = 1'b1;
                state_nxt   = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
        // Reset aborts at once: nothing reaches the bus during the reset cycle.
        if (reset) begin
            address2    = ADDR_CMD;
            chipselect2 = 1'b0;
            write2      = 1'b0;
            writedata2  = '0;
            busy        = 1'b0;
            done_pulse  = 1'b0;
        end
        byteenable2 = chipselect2 ? 4'hF : 4'h0;
    end

endmodule

// File: tb/tb_ram_mailbox_avg.sv
// Directed bench: a 4-word RAM model on s2 with an HPS-side write port, and
// per-feature tasks checking results, status, timing and reset behaviour.
module tb_ram_mailbox_avg;

    localparam int POLL = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address2;
    logic        chipselect2;
    logic        write2;
    logic [31:0] writedata2;
    logic [3:0]  byteenable2;
    logic [31:0] readdata2 = '0;
    logic        busy;
    logic        done_pulse;

    logic [31:0] mem [4];
    logic        hps_we = 1'b0;
    logic [1:0]  hps_addr = '0;
    logic [31:0] hps_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int rdcmd_cyc = 0;
    int wr_cnt = 0;
    int wr_rel [4];
    int done_cnt = 0;
    int done_rel = 0;
    int busy_run = 0;
    int busy_at_done = 0;
    int be_err = 0;

    ram_mailbox_avg #(.POLL_INTERVAL(POLL)) dut (
        .clk         (clk),
        .reset       (reset),
        .address2    (address2),
        .chipselect2 (chipselect2),
        .write2      (write2),
        .writedata2  (writedata2),
        .byteenable2 (byteenable2),
        .readdata2   (readdata2),
        .busy        (busy),
        .done_pulse  (done_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (hps_we) mem[hps_addr] <= hps_data;
        if (chipselect2 && write2) mem[address2] <= writedata2;
        if (chipselect2 && !write2) readdata2 <= mem[address2];
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (chipselect2 && !write2 && address2 == 2'd0) begin
            rdcmd_cyc <= cyc;
            busy_run  <= 0;
        end else if (busy) begin
            busy_run <= busy_run + 1;
        end
        if (chipselect2 && write2) begin
            wr_cnt <= wr_cnt + 1;
            wr_rel[address2] <= cyc - rdcmd_cyc + 1;
        end
        if (done_pulse) begin
            done_cnt     <= done_cnt + 1;
            done_rel     <= cyc - rdcmd_cyc + 1;
            busy_at_done <= busy_run + 1;
        end
        if (byteenable2 !== (chipselect2 ? 4'hF : 4'h0)) be_err <= be_err + 1;
    end

    task automatic hps_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        hps_we = 1'b1; hps_addr = a; hps_data = d;
        @(negedge clk);
        hps_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) hps_write(2'(i), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start;
        bit seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != start) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: done_pulse not seen within 200 cycles (got none, need 1)", name);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_fall: got %b need 0", name, busy);
        end
    endtask

    task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] smp,
                           input logic [31:0] exp_res, input logic [31:0] exp_stat,
                           input string name);
        hps_write(2'd1, smp);
        hps_write(2'd0, cmd);
        wait_done(name);
        n_tests++;
        if (mem[2] !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h need %h", name, mem[2], exp_res);
        end
        n_tests++;
        if (mem[3] !== exp_stat) begin
            n_fail++;
            $display("FAIL %s status: got %h need %h", name, mem[3], exp_stat);
        end
        n_tests++;
        if (mem[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL %s cmd_clear: got %h need 0", name, mem[0]);
        end
    endtask

    task automatic test_reset();
        int n1, n2;
        @(negedge clk);
        n_tests++;
        if ({address2, chipselect2, write2, writedata2, byteenable2, busy, done_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cs=%b we=%b busy=%b done=%b need all 0",
                     chipselect2, write2, busy, done_pulse);
        end
        do_reset();
        n1 = 0;
        for (int i = 1; i <= 60 && n1 == 0; i++) begin
            @(posedge clk); @(negedge clk);
            if (chipselect2) n1 = i;
        end
        n_tests++;
        if (n1 != POLL) begin
            n_fail++;
            $display("FAIL first_poll: got %0d cycles need %0d", n1, POLL);
        end
        n_tests++;
        if (address2 !== 2'd0 || write2 !== 1'b0) begin
            n_fail++;
            $display("FAIL poll_access: got addr=%0d we=%b need addr=0 we=0", address2, write2);
        end
        n2 = 0;
        for (int i = 1; i <= 60 && n2 == 0; i++) begin
            @(posedge clk); @(negedge clk);
            if (chipselect2) n2 = i;
        end
        n_tests++;
        if (n2 != POLL + 2) begin
            n_fail++;
            $display("FAIL poll_period: got %0d cycles need %0d", n2, POLL + 2);
        end
        @(posedge clk);
        n_tests++;
        if (wr_cnt != 0 || done_cnt != 0 || busy_run != 0) begin
            n_fail++;
            $display("FAIL empty_poll: got writes=%0d done=%0d busy=%0d need 0 0 0",
                     wr_cnt, done_cnt, busy_run);
        end
    endtask

    task automatic test_single();
        do_reset();
        run_cmd(32'h1, 32'd100, 32'd25, 32'h0001_0001, "single");
        n_tests++;
        if (done_rel != 8) begin
            n_fail++;
            $display("FAIL single done_cycle: got %0d need 8", done_rel);
        end
        n_tests++;
        if (wr_rel[2] != 6 || wr_rel[3] != 7 || wr_rel[0] != 8) begin
            n_fail++;
            $display("FAIL single write_cycles: got %0d %0d %0d need 6 7 8",
                     wr_rel[2], wr_rel[3], wr_rel[0]);
        end
        n_tests++;
        if (busy_at_done != 6) begin
            n_fail++;
            $display("FAIL single busy_len: got %0d need 6", busy_at_done);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        run_cmd(32'h1, 32'd100, 32'd25,  32'h0001_0001, "ramp0");
        run_cmd(32'h1, 32'd200, 32'd75,  32'h0002_0001, "ramp1");
        run_cmd(32'h1, 32'd300, 32'd150, 32'h0003_0001, "ramp2");
        run_cmd(32'h1, 32'd400, 32'd250, 32'h0004_0001, "ramp3");
    endtask

    task automatic test_negative_clr();
        // History is 100..400 from the ramp; CLR must discard it.
        run_cmd(32'h3, 32'h0000_FFFD, 32'hFFFF_FFFF, 32'h0005_0001, "neg_clr");
        run_cmd(32'h1, 32'h0000_8000, 32'hFFFF_DFFF, 32'h0006_0001, "neg_min");
        n_tests++;
        if (be_err != 0) begin
            n_fail++;
            $display("FAIL byteenable: got %0d bad cycles need 0", be_err);
        end
    endtask

    task automatic test_reset_mid_op();
        int wr0;
        bit found;
        do_reset();
        hps_write(2'd1, 32'd40);
        hps_write(2'd0, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (chipselect2 && !write2 && address2 == 2'd1) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrst RD_SMP: not reached within 100 cycles");
        end
        @(negedge clk);
        wr0 = wr_cnt;
        reset = 1'b1;
        #1;
        n_tests++;
        if (chipselect2 !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst outputs: got cs=%b busy=%b need 0 0", chipselect2, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        n_tests++;
        if (wr_cnt != wr0 || mem[3] !== 32'h0 || mem[0] !== 32'h1) begin
            n_fail++;
            $display("FAIL midrst no_write: got writes=%0d stat=%h cmd=%h need %0d 0 1",
                     wr_cnt - wr0, mem[3], mem[0], 0);
        end
        wait_done("midrst");
        n_tests++;
        if (mem[2] !== 32'd10 || mem[3] !== 32'h0001_0001) begin
            n_fail++;
            $display("FAIL midrst service: got res=%h stat=%h need 0000000a 00010001",
                     mem[2], mem[3]);
        end
    endtask

    task automatic test_wrap();
        // Reaching 0xFFFF by 65535 real commands is too slow; load it directly.
        do_reset();
        force dut.count_q = 16'hFFFF;
        run_cmd(32'h1, 32'd8, 32'd2, 32'h0000_0001, "wrap");
        release dut.count_q;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem[i]    = '0;
            wr_rel[i] = 0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_ramp();
        test_negative_clr();
        test_reset_mid_op();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
